clk_enable_generate_multi: RTL and testbench

//  Multi-channel, runtime-programmable clock-enable generator for the downsampler chain.

---
 rtl/clk_enable_generate_multi.sv | 200 ++++++++++++++++++++
 tb/tb_clk_enable_generate_multi.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_generate_multi.sv
// ----------------------------------------------------------------------------
// clk_enable_generate_multi
//
// Multi-channel, runtime-programmable clock-enable generator. Each channel
// counts ticks modulo its effective divide ratio D and emits a registered
// one-cycle strobe on the wrapping tick. A channel ticks on every clock while
// enable is high, or, when its CASCADE bit is set, on the terminal condition
// of the channel below it, so cascaded decimation stages stay phase-locked.
//
// New divide/phase values are captured into per-channel shadow registers by
// load and applied glitch-free at the channel's next wrap. sync restarts all
// channels at their (clamped) phase and applies any pending shadow at once.
//
// Ports
//   clk            in   system clock, rising edge
//   rstn           in   asynchronous active-low reset
//   enable         in   global run; low freezes all counters
//   load           in   capture div_in/phase_in into the shadow registers
//   sync           in   restart all channels at their phase
//   div_in         in   per-channel divide ratio, ch k at [k*CNT_W +: CNT_W]
//   phase_in       in   per-channel start phase, same packing
//   clk_enable     out  per-channel registered strobe, one cycle wide
//   update_pending out  shadow captured but not yet applied
// ----------------------------------------------------------------------------
module clk_enable_generate_multi #(
    parameter int unsigned     N_CH        = 4,
    parameter int unsigned     CNT_W       = 16,
    parameter int unsigned     DEFAULT_DIV = 100,
    parameter logic [N_CH-1:0] CASCADE     = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  sync,
    input  logic [N_CH*CNT_W-1:0] div_in,
    input  logic [N_CH*CNT_W-1:0] phase_in,
    output logic [N_CH-1:0]       clk_enable,
    output logic [N_CH-1:0]       update_pending
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    // D of 0 or 1 both mean "strobe on every tick".
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        return (d <= ONE) ? ONE : d;
    endfunction

    // Phase is a start count, so it must lie inside [0, D-1].
    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] p,
                                                     input logic [CNT_W-1:0] d_eff);
        return (p >= d_eff) ? (d_eff - ONE) : p;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q       [N_CH];
    logic [CNT_W-1:0] cnt_d       [N_CH];
    logic [CNT_W-1:0] div_q       [N_CH];
    logic [CNT_W-1:0] div_d       [N_CH];
    logic [CNT_W-1:0] phase_q     [N_CH];
    logic [CNT_W-1:0] phase_d     [N_CH];
    logic [CNT_W-1:0] shd_div_q   [N_CH];
    logic [CNT_W-1:0] shd_div_d   [N_CH];
    logic [CNT_W-1:0] shd_phase_q [N_CH];
    logic [CNT_W-1:0] shd_phase_d [N_CH];
    logic [N_CH-1:0]  pend_q;
    logic [N_CH-1:0]  pend_d;
    logic [N_CH-1:0]  stb_q;
    logic [N_CH-1:0]  stb_d;

    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  term;

    // ------------------------------------------------------------------------
    // Tick and terminal chain. The terminal of channel k-1 is taken before the
    // output register, so a cascaded strobe lands on the same cycle as its
    // parent's strobe. A running variable carries the chain to keep the
    // evaluation strictly ordered from channel 0 upward.
    // ------------------------------------------------------------------------
    always_comb begin
        logic parent_term;
        logic tick_k;
        logic term_k;
        parent_term = 1'b0;
        tick        = '0;
        term        = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            tick_k      = (k != 0 && CASCADE[k]) ? parent_term : enable;
            term_k      = tick_k && (cnt_q[k] == (eff_div(div_q[k]) - ONE));
            tick[k]     = tick_k;
            term[k]     = term_k;
            parent_term = term_k;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        logic [CNT_W-1:0] in_div;
        logic [CNT_W-1:0] in_phase;
        logic [CNT_W-1:0] new_div;
        logic [CNT_W-1:0] new_phase;
        for (int k = 0; k < int'(N_CH); k++) begin
            cnt_d[k]       = cnt_q[k];
            div_d[k]       = div_q[k];
            phase_d[k]     = phase_q[k];
            shd_div_d[k]   = shd_div_q[k];
            shd_phase_d[k] = shd_phase_q[k];
        end
        pend_d    = pend_q;
        stb_d     = '0;
        in_div    = '0;
        in_phase  = '0;
        new_div   = '0;
        new_phase = '0;

        for (int k = 0; k < int'(N_CH); k++) begin
            in_div   = div_in[k*CNT_W +: CNT_W];
            in_phase = phase_in[k*CNT_W +: CNT_W];

            if (sync) begin
                // Realign: freshest value wins (load in the same cycle beats
                // a pending shadow, which beats the active value).
                if (load) begin
                    new_div   = in_div;
                    new_phase = in_phase;
                end else if (pend_q[k]) begin
                    new_div   = shd_div_q[k];
                    new_phase = shd_phase_q[k];
                end else begin
                    new_div   = div_q[k];
                    new_phase = phase_q[k];
                end
                div_d[k]       = new_div;
                phase_d[k]     = new_phase;
                shd_div_d[k]   = new_div;
                shd_phase_d[k] = new_phase;
                pend_d[k]      = 1'b0;
                cnt_d[k]       = clamp_phase(new_phase, eff_div(new_div));
            end else begin
                if (tick[k]) begin
                    if (term[k]) begin
                        cnt_d[k] = '0;
                        stb_d[k] = 1'b1;
                        // Wrap applies the shadow as it stood before this edge;
                        // a load on the same edge lands in the shadow below and
                        // waits for the next wrap.
                        if (pend_q[k]) begin
                            div_d[k]   = shd_div_q[k];
                            phase_d[k] = shd_phase_q[k];
                            pend_d[k]  = 1'b0;
                        end
                    end else begin
                        cnt_d[k] = cnt_q[k] + ONE;
                    end
                end
                if (load) begin
                    shd_div_d[k]   = in_div;
                    shd_phase_d[k] = in_phase;
                    pend_d[k]      = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                cnt_q[k]       <= '0;
                div_q[k]       <= DIV_RST;
                phase_q[k]     <= '0;
                shd_div_q[k]   <= DIV_RST;
                shd_phase_q[k] <= '0;
            end
            pend_q <= '0;
            stb_q  <= '0;
        end else begin
            for (int k = 0; k < int'(N_CH); k++) begin
                cnt_q[k]       <= cnt_d[k];
                div_q[k]       <= div_d[k];
                phase_q[k]     <= phase_d[k];
                shd_div_q[k]   <= shd_div_d[k];
                shd_phase_q[k] <= shd_phase_d[k];
            end
            pend_q <= pend_d;
            stb_q  <= stb_d;
        end
    end

    assign clk_enable     = stb_q;
    assign update_pending = pend_q;

endmodule

// File: tb/tb_clk_enable_generate_multi.sv
// Testbench for clk_enable_generate_multi: directed scenarios plus a random
// run, all checked against a tick-position model kept in the bench.
module tb_clk_enable_generate_multi;

    localparam int        NCH  = 4;
    localparam int        CW   = 16;
    localparam int        DDIV = 100;
    localparam logic [3:0] CASC = 4'b1010;

    logic            clk;
    logic            rstn;
    logic            enable;
    logic            load;
    logic            sync;
    logic [NCH*CW-1:0] div_in;
    logic [NCH*CW-1:0] phase_in;
    logic [NCH-1:0]  clk_enable;
    logic [NCH-1:0]  update_pending;

    clk_enable_generate_multi #(
        .N_CH        (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV),
        .CASCADE     (CASC)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .load           (load),
        .sync           (sync),
        .div_in         (div_in),
        .phase_in       (phase_in),
        .clk_enable     (clk_enable),
        .update_pending (update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Stimulus values per channel
    int in_div [NCH];
    int in_ph  [NCH];

    // Model: position within the period, active and shadow settings
    int m_pos  [NCH];
    int m_div  [NCH];
    int m_ph   [NCH];
    int m_sdiv [NCH];
    int m_sph  [NCH];
    bit m_pend [NCH];
    bit m_stb  [NCH];

    function automatic int effd(input int d);
        return (d <= 1) ? 1 : d;
    endfunction

    function automatic int clampp(input int p, input int d);
        return (p >= d) ? d - 1 : p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_pos[k]  = 0;
            m_div[k]  = DDIV;
            m_ph[k]   = 0;
            m_sdiv[k] = DDIV;
            m_sph[k]  = 0;
            m_pend[k] = 0;
            m_stb[k]  = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit fire [NCH];
        bit tk   [NCH];
        int nd;
        int np;
        if (sync) begin
            for (int k = 0; k < NCH; k++) begin
                nd = load ? in_div[k] : (m_pend[k] ? m_sdiv[k] : m_div[k]);
                np = load ? in_ph[k]  : (m_pend[k] ? m_sph[k]  : m_ph[k]);
                m_div[k]  = nd;
                m_ph[k]   = np;
                m_sdiv[k] = nd;
                m_sph[k]  = np;
                m_pend[k] = 0;
                m_pos[k]  = clampp(np, effd(nd));
                m_stb[k]  = 0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                tk[k]   = (k > 0 && CASC[k]) ? fire[k-1] : (enable == 1'b1);
                fire[k] = tk[k] && ((m_pos[k] + 1) % effd(m_div[k]) == 0);
            end
            for (int k = 0; k < NCH; k++) begin
                m_stb[k] = fire[k];
                if (tk[k]) m_pos[k] = (m_pos[k] + 1) % effd(m_div[k]);
                if (fire[k] && m_pend[k]) begin
                    m_div[k]  = m_sdiv[k];
                    m_ph[k]   = m_sph[k];
                    m_pend[k] = 0;
                end
                if (load) begin
                    m_sdiv[k] = in_div[k];
                    m_sph[k]  = in_ph[k];
                    m_pend[k] = 1;
                end
            end
        end
    endtask

    // One clock: drive packed inputs, step model, sample 1 time unit after the
    // edge, compare, then drop the one-cycle pulses.
    task automatic cycle(input string tag);
        logic [NCH-1:0] exp_stb;
        logic [NCH-1:0] exp_pend;
        for (int k = 0; k < NCH; k++) begin
            div_in[k*CW +: CW]   = in_div[k][CW-1:0];
            phase_in[k*CW +: CW] = in_ph[k][CW-1:0];
        end
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            exp_stb[k]  = m_stb[k];
            exp_pend[k] = m_pend[k];
        end
        n_cmp++;
        if (clk_enable !== exp_stb) begin
            n_err++;
            $display("FAIL %s clk_enable got %b expected %b at %0t", tag, clk_enable, exp_stb,
                     $time);
        end
        n_cmp++;
        if (update_pending !== exp_pend) begin
            n_err++;
            $display("FAIL %s update_pending got %b expected %b at %0t", tag, update_pending,
                     exp_pend, $time);
        end
        load = 1'b0;
        sync = 1'b0;
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %b expected %b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        sync     = 1'b0;
        div_in   = '0;
        phase_in = '0;
        for (int k = 0; k < NCH; k++) begin
            in_div[k] = 0;
            in_ph[k]  = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_int("reset_clk_enable", int'(clk_enable), 0);
        expect_int("reset_update_pending", int'(update_pending), 0);
        rstn = 1'b1;
    endtask

    // Default divide: first strobe after edge 100, then every 100 edges.
    task automatic test_default_period();
        int first;
        int second;
        first  = -1;
        second = -1;
        enable = 1'b1;
        for (int i = 1; i <= 250; i++) begin
            cycle("default_period");
            if (clk_enable[0]) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        expect_int("default_first_strobe", first, 100);
        expect_int("default_second_strobe", second, 200);
    endtask

    // ch0 D=4, ch1 cascaded D=3 -> ch1 every 12 clocks on a ch0 strobe.
    task automatic test_cascade();
        int first;
        int last;
        int cnt1;
        in_div = '{4, 3, 5, 2};
        in_ph  = '{0, 0, 0, 0};
        load = 1'b1;
        sync = 1'b1;
        cycle("cascade_sync");
        first = -1;
        last  = -1;
        cnt1  = 0;
        for (int i = 1; i <= 60; i++) begin
            cycle("cascade");
            if (clk_enable[1]) begin
                cnt1++;
                expect_bit("cascade_coincident", clk_enable[0], 1'b1);
                if (first < 0) first = i;
                else expect_int("cascade_interval", i - last, 12);
                last = i;
            end
        end
        expect_int("cascade_first", first, 12);
        expect_int("cascade_count", cnt1, 5);
    endtask

    // Load D0=10 while ch0 is mid-count in a period of 4.
    task automatic test_load_midcount();
        in_div[0] = 4;
        in_ph[0]  = 0;
        load = 1'b1;
        sync = 1'b1;
        cycle("load_mid_sync");
        cycle("load_mid");
        cycle("load_mid");
        in_div[0] = 10;
        load = 1'b1;
        cycle("load_mid_load");
        expect_bit("load_pending_set", update_pending[0], 1'b1);
        for (int i = 1; i <= 21; i++) begin
            cycle("load_mid_run");
            expect_bit("load_period_strobe", clk_enable[0], (i == 1) || (i == 11) || (i == 21));
            if (i == 1) expect_bit("load_pending_clear", update_pending[0], 1'b0);
        end
    endtask

    // sync with D=8, P=3 -> strobes at E+5, E+13; P=20 clamps to 7 -> E+1, E+9.
    task automatic test_sync_phase();
        in_div[0] = 8;
        in_ph[0]  = 3;
        load = 1'b1;
        sync = 1'b1;
        cycle("sync_p3");
        for (int i = 1; i <= 14; i++) begin
            cycle("sync_p3_run");
            expect_bit("sync_p3_strobe", clk_enable[0], (i == 5) || (i == 13));
        end
        in_ph[0] = 20;
        load = 1'b1;
        sync = 1'b1;
        cycle("sync_p20");
        for (int i = 1; i <= 9; i++) begin
            cycle("sync_p20_run");
            expect_bit("sync_p20_strobe", clk_enable[0], (i == 1) || (i == 9));
        end
    endtask

    // D=0 / D=1 give a constant strobe; enable low freezes and shifts ch2.
    task automatic test_div01_enable();
        in_div = '{0, 1, 6, 2};
        in_ph  = '{0, 0, 0, 0};
        load = 1'b1;
        sync = 1'b1;
        cycle("div01_sync");
        for (int i = 1; i <= 8; i++) begin
            cycle("div01_run");
            expect_bit("div0_continuous", clk_enable[0], 1'b1);
            expect_bit("div1_continuous", clk_enable[1], 1'b1);
            expect_bit("div6_strobe", clk_enable[2], i == 6);
        end
        enable = 1'b0;
        for (int i = 9; i <= 13; i++) begin
            cycle("enable_low");
            expect_int("enable_low_outputs", int'(clk_enable), 0);
        end
        enable = 1'b1;
        for (int i = 14; i <= 20; i++) begin
            cycle("enable_resume");
            expect_bit("resume_div0", clk_enable[0], 1'b1);
            expect_bit("resume_shift", clk_enable[2], i == 17);
        end
    endtask

    // Reset mid-period with a pending load: outputs drop at once, D back to 100.
    task automatic test_reset_mid();
        int first;
        cycle("rst_mid_pre");
        expect_bit("rst_mid_strobe_high", clk_enable[0], 1'b1);
        in_div[0] = 7;
        load = 1'b1;
        cycle("rst_mid_load");
        expect_bit("rst_mid_pending_high", update_pending[0], 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        expect_int("rst_mid_clk_enable", int'(clk_enable), 0);
        expect_int("rst_mid_pending", int'(update_pending), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        first = -1;
        for (int i = 1; i <= 110; i++) begin
            cycle("rst_mid_restart");
            if (clk_enable[0] && first < 0) first = i;
        end
        expect_int("rst_mid_first_strobe", first, 100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 15) == 0);
            sync   = ($urandom_range(0, 39) == 0);
            if (load) begin
                for (int k = 0; k < NCH; k++) begin
                    in_div[k] = int'($urandom_range(0, 12));
                    in_ph[k]  = int'($urandom_range(0, 14));
                end
            end
            cycle("random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_default_period();
        test_cascade();
        test_load_midcount();
        test_sync_phase();
        test_div01_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
